// File: rtl/rhythm_judge.sv
`default_nettype none
// ============================================================================
// Module   : rhythm_judge
// Brief    : Multi-lane rhythm-game note judge with scrolling beat maps,
//            score/combo tracking and a per-press timing verdict.
// Revision : 1.0 - initial release
// ============================================================================
module rhythm_judge #(
    parameter int LANES   = 4,
    parameter int MAP_LEN = 64,
    parameter int VIEW    = 10,
    parameter int SCORE_W = 16,
    parameter int COMBO_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     load,
    input  logic [LANES*MAP_LEN-1:0] map_in,
    input  logic [LANES-1:0]         button,
    output logic [LANES*VIEW-1:0]    view_out,
    output logic [SCORE_W-1:0]       score,
    output logic [COMBO_W-1:0]       combo,
    output logic [COMBO_W-1:0]       max_combo,
    output logic [1:0]               accuracy,
    output logic                     playing,
    output logic                     done
);

    localparam int SSUM_W = SCORE_W + 5;
    localparam int CSUM_W = COMBO_W + 4;
    localparam logic [1:0] ACC_NONE    = 2'b00;
    localparam logic [1:0] ACC_PERFECT = 2'b01;
    localparam logic [1:0] ACC_GOOD    = 2'b10;
    localparam logic [1:0] ACC_MISS    = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;

    state_t                          r_state;
    logic [LANES-1:0][MAP_LEN-1:0]   r_lane;
    logic [LANES-1:0]                r_btn_q;
    logic [SCORE_W-1:0]              r_score;
    logic [COMBO_W-1:0]              r_combo;
    logic [COMBO_W-1:0]              r_max_combo;
    logic [1:0]                      r_accuracy;
    logic                            r_playing;
    logic                            r_done;

    logic [LANES-1:0]                w_press;
    logic [LANES-1:0][MAP_LEN-1:0]   w_lane_nxt;
    logic [4:0]                      w_add;
    logic [3:0]                      w_hits;
    logic                            w_perf;
    logic                            w_good;
    logic                            w_miss;
    logic                            w_any_press;
    logic [SSUM_W-1:0]               w_score_sum;
    logic [CSUM_W-1:0]               w_combo_sum;
    logic [SCORE_W-1:0]              w_score_nxt;
    logic [COMBO_W-1:0]              w_combo_nxt;
    logic [1:0]                      w_acc_nxt;

    assign w_press = button & ~r_btn_q;

    // Presses are judged on the pre-shift map, so a note hit on the tick
    // cycle is already cleared before the miss scan looks at slot 0.
    always_comb begin
        w_lane_nxt  = r_lane;
        w_add       = '0;
        w_hits      = '0;
        w_perf      = 1'b0;
        w_good      = 1'b0;
        w_miss      = 1'b0;
        w_any_press = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (w_press[k]) begin
                w_any_press = 1'b1;
                if (w_lane_nxt[k][1]) begin
                    w_lane_nxt[k][1] = 1'b0;
                    w_add            = w_add + 5'd2;
                    w_hits           = w_hits + 4'd1;
                    w_perf           = 1'b1;
                end else if (w_lane_nxt[k][0]) begin
                    w_lane_nxt[k][0] = 1'b0;
                    w_add            = w_add + 5'd1;
                    w_hits           = w_hits + 4'd1;
                    w_good           = 1'b1;
                end else if (w_lane_nxt[k][2]) begin
                    w_lane_nxt[k][2] = 1'b0;
                    w_add            = w_add + 5'd1;
                    w_hits           = w_hits + 4'd1;
                    w_good           = 1'b1;
                end
            end
        end
        if (tick) begin
            for (int k = 0; k < LANES; k++) begin
                if (w_lane_nxt[k][0]) begin
                    w_miss = 1'b1;
                end
                w_lane_nxt[k] = w_lane_nxt[k] >> 1;
            end
        end
    end

    assign w_score_sum = SSUM_W'(r_score) + SSUM_W'(w_add);
    assign w_combo_sum = CSUM_W'(r_combo) + CSUM_W'(w_hits);
    assign w_score_nxt = (w_score_sum[SSUM_W-1:SCORE_W] != '0) ? {SCORE_W{1'b1}}
                                                               : w_score_sum[SCORE_W-1:0];
    assign w_combo_nxt = w_miss ? '0 :
                         (w_combo_sum[CSUM_W-1:COMBO_W] != '0) ? {COMBO_W{1'b1}}
                                                               : w_combo_sum[COMBO_W-1:0];
    assign w_acc_nxt   = w_miss      ? ACC_MISS    :
                         w_perf      ? ACC_PERFECT :
                         w_good      ? ACC_GOOD    :
                         w_any_press ? ACC_NONE    : r_accuracy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lane      <= '0;
            r_btn_q     <= '0;
            r_score     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_accuracy  <= ACC_NONE;
            r_playing   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_btn_q <= button;
            if (load) begin
                r_state     <= PLAY;
                r_lane      <= map_in;
                r_score     <= '0;
                r_combo     <= '0;
                r_max_combo <= '0;
                r_accuracy  <= ACC_NONE;
                r_playing   <= 1'b1;
                r_done      <= 1'b0;
            end else if (r_state == PLAY) begin
                r_lane     <= w_lane_nxt;
                r_score    <= w_score_nxt;
                r_combo    <= w_combo_nxt;
                r_accuracy <= w_acc_nxt;
                if (w_combo_nxt > r_max_combo) begin
                    r_max_combo <= w_combo_nxt;
                end
                if (r_lane == '0) begin
                    r_state   <= DONE;
                    r_playing <= 1'b0;
                    r_done    <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_view
        assign view_out[k*VIEW +: VIEW] = r_lane[k][VIEW:1];
    end

    assign score     = r_score;
    assign combo     = r_combo;
    assign max_combo = r_max_combo;
    assign accuracy  = r_accuracy;
    assign playing   = r_playing;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rhythm_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_rhythm_judge
// Brief    : Directed and randomized bench for rhythm_judge against a
//            lane-array reference model; a second instance has a 2-bit score.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rhythm_judge;

    localparam int LANES   = 2;
    localparam int MAP_LEN = 8;
    localparam int VIEW    = 4;
    localparam int COMBO_W = 2;
    localparam int SCORE_W = 8;
    localparam int SMAX_A  = 255;
    localparam int SMAX_B  = 3;
    localparam int CMAX    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        load = 1'b0;
    logic [15:0] map_in = '0;
    logic [1:0]  button = '0;

    logic [7:0] view_a, view_b;
    logic [7:0] score_a;
    logic [1:0] score_b;
    logic [1:0] combo_a, combo_b, max_a, max_b, acc_a, acc_b;
    logic       playing_a, playing_b, done_a, done_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_lane [2];
    logic [1:0] m_btnq;
    int         m_state;
    int         m_score, m_score_s, m_combo, m_max;
    logic [1:0] m_acc;

    rhythm_judge #(.LANES(LANES), .MAP_LEN(MAP_LEN), .VIEW(VIEW),
                   .SCORE_W(SCORE_W), .COMBO_W(COMBO_W)) u_dut_a (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .map_in(map_in),
        .button(button), .view_out(view_a), .score(score_a), .combo(combo_a),
        .max_combo(max_a), .accuracy(acc_a), .playing(playing_a), .done(done_a));

    rhythm_judge #(.LANES(LANES), .MAP_LEN(MAP_LEN), .VIEW(VIEW),
                   .SCORE_W(2), .COMBO_W(COMBO_W)) u_dut_b (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .map_in(map_in),
        .button(button), .view_out(view_b), .score(score_b), .combo(combo_b),
        .max_combo(max_b), .accuracy(acc_b), .playing(playing_b), .done(done_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        logic [1:0] press;
        int  pts, hits;
        bit  perf, good, miss, was_empty;
        press = button & ~m_btnq;
        if (rst) begin
            m_lane[0] = '0; m_lane[1] = '0; m_btnq = '0; m_state = 0;
            m_score = 0; m_score_s = 0; m_combo = 0; m_max = 0; m_acc = 2'b00;
            return;
        end
        m_btnq = button;
        if (load) begin
            m_lane[0] = map_in[7:0];
            m_lane[1] = map_in[15:8];
            m_score = 0; m_score_s = 0; m_combo = 0; m_max = 0; m_acc = 2'b00;
            m_state = 1;
        end else if (m_state == 1) begin
            was_empty = (m_lane[0] == 0) && (m_lane[1] == 0);
            pts = 0; hits = 0; perf = 0; good = 0; miss = 0;
            for (int k = 0; k < 2; k++) begin
                if (press[k]) begin
                    if (m_lane[k][1])      begin pts += 2; hits++; perf = 1; m_lane[k][1] = 1'b0; end
                    else if (m_lane[k][0]) begin pts += 1; hits++; good = 1; m_lane[k][0] = 1'b0; end
                    else if (m_lane[k][2]) begin pts += 1; hits++; good = 1; m_lane[k][2] = 1'b0; end
                end
            end
            if (tick) begin
                for (int k = 0; k < 2; k++) begin
                    if (m_lane[k][0]) miss = 1;
                    m_lane[k] = m_lane[k] >> 1;
                end
            end
            m_score   = min_i(m_score + pts, SMAX_A);
            m_score_s = min_i(m_score_s + pts, SMAX_B);
            m_combo   = miss ? 0 : min_i(m_combo + hits, CMAX);
            if (m_combo > m_max) m_max = m_combo;
            if (miss)              m_acc = 2'b11;
            else if (perf)         m_acc = 2'b01;
            else if (good)         m_acc = 2'b10;
            else if (press != 0)   m_acc = 2'b00;
            if (was_empty) m_state = 2;
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_view;
        for (int k = 0; k < 2; k++) exp_view[k*4 +: 4] = m_lane[k][4:1];
        check("score_a",   score_a,   m_score);
        check("score_b",   score_b,   m_score_s);
        check("combo",     combo_a,   m_combo);
        check("max_combo", max_a,     m_max);
        check("accuracy",  acc_a,     m_acc);
        check("playing",   playing_a, m_state == 1);
        check("done",      done_a,    m_state == 2);
        check("view",      view_a,    exp_view);
        check("view_b",    view_b,    exp_view);
        check("combo_b",   combo_b,   m_combo);
        check("acc_b",     acc_b,     m_acc);
    endtask

    task automatic cycle(input logic r, input logic l, input logic t,
                         input logic [1:0] b, input logic [15:0] m);
        rst = r; load = l; tick = t; button = b; map_in = m;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        int i;
        m_btnq = '0;
        // Reset held two cycles
        cycle(1, 0, 0, 2'b00, 16'h0);
        cycle(1, 0, 0, 2'b00, 16'h0);
        check("rst_score", score_a, 0);
        check("rst_playing", playing_a, 0);
        check("rst_view", view_a, 0);

        // Perfect hit then tick with no miss
        cycle(0, 1, 0, 2'b00, {8'h00, 8'h02});
        cycle(0, 0, 0, 2'b01, 16'h0);
        check("perf_acc", acc_a, 1);
        check("perf_score", score_a, 2);
        check("perf_combo", combo_a, 1);
        cycle(0, 0, 1, 2'b00, 16'h0);
        check("perf_tick_combo", combo_a, 1);
        check("perf_tick_acc", acc_a, 1);

        // Miss on tick
        cycle(0, 1, 0, 2'b00, {8'h00, 8'h01});
        cycle(0, 0, 1, 2'b00, 16'h0);
        check("miss_acc", acc_a, 3);
        check("miss_combo", combo_a, 0);
        check("miss_score", score_a, 0);

        // Press coinciding with tick on slot 0
        cycle(0, 1, 0, 2'b00, {8'h00, 8'h01});
        cycle(0, 0, 1, 2'b01, 16'h0);
        check("coin_acc", acc_a, 2);
        check("coin_score", score_a, 1);
        check("coin_combo", combo_a, 1);

        // Two lanes perfect together
        cycle(0, 1, 0, 2'b00, {8'h02, 8'h02});
        cycle(0, 0, 0, 2'b11, 16'h0);
        check("dual_score", score_a, 4);
        check("dual_score_sat", score_b, 3);
        check("dual_combo", combo_a, 2);

        // Five consecutive hits saturate combo and narrow score
        cycle(0, 1, 0, 2'b00, {8'h03, 8'h07});
        cycle(0, 0, 0, 2'b11, 16'h0);
        cycle(0, 0, 0, 2'b00, 16'h0);
        cycle(0, 0, 0, 2'b11, 16'h0);
        cycle(0, 0, 0, 2'b00, 16'h0);
        cycle(0, 0, 0, 2'b01, 16'h0);
        check("sat_combo", combo_a, 3);
        check("sat_max", max_a, 3);
        check("sat_score_b", score_b, 3);
        check("sat_score_a", score_a, 7);

        // Completion by ticks
        cycle(0, 1, 0, 2'b00, {8'h00, 8'h04});
        for (i = 0; i < 20 && !done_a; i++) cycle(0, 0, 1, 2'b00, 16'h0);
        check("end_done", done_a, 1);
        check("end_playing", playing_a, 0);
        cycle(0, 0, 1, 2'b11, 16'h0);
        check("end_press_combo", combo_a, 0);
        check("end_press_acc", acc_a, 3);
        cycle(0, 1, 0, 2'b00, {8'h10, 8'h20});
        check("reload_playing", playing_a, 1);
        check("reload_max", max_a, 0);

        // Reset aborts mid-map
        cycle(1, 1, 1, 2'b11, 16'hffff);
        check("abort_playing", playing_a, 0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 2) == 0, 2'($urandom), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
